// File: rtl/axi4lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi4lite_reg_slave
//
// AXI4-Lite responder with four 32-bit read/write registers at byte offsets
// 0x0, 0x4, 0x8 and 0xC. Every access completes with an OKAY response.
//
// Ports
//   S_AXI_ACLK     clock, everything on the rising edge
//   S_AXI_ARESET   synchronous active-high reset
//   S_AXI_AW*      write address channel (AWPROT ignored)
//   S_AXI_W*       write data channel, WSTRB gives byte enables
//   S_AXI_B*       write response channel, BRESP always OKAY
//   S_AXI_AR*      read address channel (ARPROT ignored)
//   S_AXI_R*       read data channel, RRESP always OKAY
//   slv_regs       {reg3, reg2, reg1, reg0} for user logic
//   reg_wr_stb     one-cycle pulse on bit i when register i is written
//
// Handshake rule (all five channels): a transfer happens on a rising edge
// where both VALID and READY are high. The master holds VALID and payload
// stable until that edge; this block holds BVALID/RVALID and their payload
// stable until an edge with BREADY/RREADY high.
//
// Only a 32-bit data bus is supported. Address bits [3:2] select the
// register; bits [1:0] are ignored.
// ---------------------------------------------------------------------------
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   slv_regs,
  output logic [3:0]                        reg_wr_stb
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  // Gates all READY outputs so nothing is accepted on the first edge out of reset.
  logic          ready_en_q;

  // Write path state
  logic          aw_held_q;
  logic          w_held_q;
  logic          bvalid_q;
  logic [1:0]    aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [3:0]    wr_stb_q;

  // Read path state
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  // Register file
  logic [DW-1:0] regs_q [4];

  logic          aw_ready;
  logic          w_ready;
  logic          ar_ready;
  logic          aw_fire;
  logic          w_fire;
  logic          ar_fire;
  logic          wr_commit;
  logic [DW-1:0] wr_data_d;

  assign aw_ready  = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign w_ready   = ready_en_q & ~w_held_q  & ~bvalid_q;
  assign ar_ready  = ready_en_q & ~rvalid_q;

  assign aw_fire   = S_AXI_AWVALID & aw_ready;
  assign w_fire    = S_AXI_WVALID  & w_ready;
  assign ar_fire   = S_AXI_ARVALID & ar_ready;

  // Both halves of a write are parked before commit, so the commit edge is
  // always one edge after the later of the two handshakes.
  assign wr_commit = aw_held_q & w_held_q;

  // Byte-wise merge of the held write data into the addressed register.
  always_comb begin
    wr_data_d = regs_q[aw_idx_q];
    for (int b = 0; b < SW; b++) begin
      if (wstrb_q[b]) begin
        wr_data_d[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_stb_q   <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      ready_en_q <= 1'b1;
      wr_stb_q   <= '0;

      if (aw_fire) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[3:2];
      end
      if (w_fire) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end

      // A commit cannot coincide with a new AW/W handshake: both READYs are
      // low while the flags are set.
      if (wr_commit) begin
        regs_q[aw_idx_q] <= wr_data_d;
        aw_held_q        <= 1'b0;
        w_held_q         <= 1'b0;
        bvalid_q         <= 1'b1;
        wr_stb_q         <= 4'b0001 << aw_idx_q;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      // Reads sample regs_q before this edge's write lands, so a same-edge
      // collision returns the old contents. RDATA is left as-is when RVALID drops.
      if (ar_fire) begin
        rdata_q  <= regs_q[S_AXI_ARADDR[3:2]];
        rvalid_q <= 1'b1;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign slv_regs      = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign reg_wr_stb    = wr_stb_q;

  // Inputs that carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_reg_slave
//
// Drives the AXI4-Lite slave from directed sequences plus randomized
// read/write traffic and compares against a register-array reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_axi4lite_reg_slave;

  // ---------------- clock / reset ----------------
  logic clk;
  logic areset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]   s_axi_awaddr;
  logic [2:0]   s_axi_awprot;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [3:0]   s_axi_araddr;
  logic [2:0]   s_axi_arprot;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic [127:0] slv_regs;
  logic [3:0]   reg_wr_stb;

  axi4lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (areset),
    .S_AXI_AWADDR (s_axi_awaddr),
    .S_AXI_AWPROT (s_axi_awprot),
    .S_AXI_AWVALID(s_axi_awvalid),
    .S_AXI_AWREADY(s_axi_awready),
    .S_AXI_WDATA  (s_axi_wdata),
    .S_AXI_WSTRB  (s_axi_wstrb),
    .S_AXI_WVALID (s_axi_wvalid),
    .S_AXI_WREADY (s_axi_wready),
    .S_AXI_BRESP  (s_axi_bresp),
    .S_AXI_BVALID (s_axi_bvalid),
    .S_AXI_BREADY (s_axi_bready),
    .S_AXI_ARADDR (s_axi_araddr),
    .S_AXI_ARPROT (s_axi_arprot),
    .S_AXI_ARVALID(s_axi_arvalid),
    .S_AXI_ARREADY(s_axi_arready),
    .S_AXI_RDATA  (s_axi_rdata),
    .S_AXI_RRESP  (s_axi_rresp),
    .S_AXI_RVALID (s_axi_rvalid),
    .S_AXI_RREADY (s_axi_rready),
    .slv_regs     (slv_regs),
    .reg_wr_stb   (reg_wr_stb)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks;
  int          n_fail;
  logic [31:0] model_regs [4];
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model_regs[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  function automatic logic [127:0] model_slv();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  function automatic logic [44:0] out_bundle();
    return {s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
            s_axi_rdata, s_axi_rresp, s_axi_rvalid, reg_wr_stb};
  endfunction

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int cyc;
    bit aw_done;
    bit w_done;
    bit aw_fire;
    bit w_fire;
    logic [3:0] exp_stb;
    exp_stb = 4'b0000;
    exp_stb[addr[3:2]] = 1'b1;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    s_axi_bready = 1'b0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wvalid  = !w_done  && (cyc >= w_dly);
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid  && s_axi_wready;
      @(negedge clk);
      if (aw_fire) aw_done = 1'b1;
      if (w_fire)  w_done  = 1'b1;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check_eq("wr_handshake", {aw_done, w_done}, 2'b11);
    // Commit lands one edge after the later handshake.
    check_eq("wr_bvalid_early", s_axi_bvalid, 1'b0);
    @(negedge clk);
    model_write(addr, data, strb);
    check_eq("wr_bvalid", s_axi_bvalid, 1'b1);
    check_eq("wr_bresp", s_axi_bresp, 2'b00);
    check_eq("wr_stb", reg_wr_stb, exp_stb);
    check_eq("wr_slv_regs", slv_regs, model_slv());
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check_eq("wr_bvalid_hold", s_axi_bvalid, 1'b1);
      check_eq("wr_ready_blocked", {s_axi_awready, s_axi_wready}, 2'b00);
      check_eq("wr_stb_once", reg_wr_stb, 4'b0000);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    check_eq("wr_bvalid_clear", s_axi_bvalid, 1'b0);
    check_eq("wr_stb_clear", reg_wr_stb, 4'b0000);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_dly);
    int cyc;
    bit done;
    bit fire;
    logic [31:0] exp;
    s_axi_araddr = addr;
    s_axi_rready = 1'b0;
    exp_q.push_back(model_regs[addr[3:2]]);
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 100) begin
      s_axi_arvalid = 1'b1;
      fire = s_axi_arready;
      @(negedge clk);
      if (fire) done = 1'b1;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    check_eq("rd_handshake", done, 1'b1);
    exp = exp_q.pop_front();
    check_eq("rd_rvalid", s_axi_rvalid, 1'b1);
    check_eq("rd_rdata", s_axi_rdata, exp);
    check_eq("rd_rresp", s_axi_rresp, 2'b00);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check_eq("rd_rvalid_hold", s_axi_rvalid, 1'b1);
      check_eq("rd_rdata_hold", s_axi_rdata, exp);
      check_eq("rd_arready_blocked", s_axi_arready, 1'b0);
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    check_eq("rd_rvalid_clear", s_axi_rvalid, 1'b0);
    check_eq("rd_rdata_keep", s_axi_rdata, exp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0] old_val;
  logic [31:0] seq_data [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    areset        = 1'b1;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;

    // Reset held 25 cycles: everything reads back as zero.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check_eq("rst_outputs", out_bundle(), '0);
      check_eq("rst_slv_regs", slv_regs, '0);
    end
    areset = 1'b0;
    check_eq("rst_ready_at_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    @(negedge clk);
    check_eq("rst_ready_after", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // Sequential write then readback.
    seq_data[0] = 32'h0101_FFFF;
    seq_data[1] = 32'habcd_0001;
    seq_data[2] = 32'hdead_0011;
    seq_data[3] = 32'hbeef_0011;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), seq_data[i], 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // Byte strobes on reg1.
    axi_write(4'h4, 32'h1122_3344, 4'b0101, 0, 0, 0);
    check_eq("strb_reg1", slv_regs[63:32], 32'hab22_0044);
    axi_read(4'h4, 0);
    // Zero strobe: register untouched, strobe still pulses.
    axi_write(4'h0, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);
    axi_read(4'h0, 1);

    // W three cycles ahead of AW, response held off four cycles.
    s_axi_awaddr = 4'hC;
    s_axi_wdata  = 32'h0f0f_0f0f;
    s_axi_wstrb  = 4'hF;
    s_axi_bready = 1'b0;
    s_axi_wvalid = 1'b1;
    check_eq("ooo_wready", s_axi_wready, 1'b1);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("ooo_w_held", {s_axi_awready, s_axi_wready, s_axi_bvalid}, 3'b100);
      @(negedge clk);
    end
    s_axi_awvalid = 1'b1;
    check_eq("ooo_awready", s_axi_awready, 1'b1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    check_eq("ooo_no_early_b", s_axi_bvalid, 1'b0);
    @(negedge clk);
    model_write(4'hC, 32'h0f0f_0f0f, 4'hF);
    check_eq("ooo_stb", reg_wr_stb, 4'b1000);
    check_eq("ooo_slv_regs", slv_regs, model_slv());
    for (int i = 0; i < 4; i++) begin
      check_eq("ooo_bvalid_hold", s_axi_bvalid, 1'b1);
      check_eq("ooo_ready_low", {s_axi_awready, s_axi_wready}, 2'b00);
      if (i == 3) s_axi_bready = 1'b1;
      @(negedge clk);
    end
    s_axi_bready = 1'b0;
    check_eq("ooo_bvalid_clear", s_axi_bvalid, 1'b0);
    check_eq("ooo_ready_back", {s_axi_awready, s_axi_wready}, 2'b11);
    axi_read(4'hC, 0);

    // Read and write commit to reg2 on the same edge; read sees the old value.
    old_val = model_regs[2];
    s_axi_awaddr  = 4'h8;
    s_axi_wdata   = 32'h55AA_55AA;
    s_axi_wstrb   = 4'hF;
    s_axi_bready  = 1'b1;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    check_eq("col_wr_ready", {s_axi_awready, s_axi_wready}, 2'b11);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_araddr  = 4'h8;
    s_axi_rready  = 1'b0;
    s_axi_arvalid = 1'b1;
    check_eq("col_arready", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    model_write(4'h8, 32'h55AA_55AA, 4'hF);
    check_eq("col_bvalid", s_axi_bvalid, 1'b1);
    check_eq("col_slv_reg2", slv_regs[95:64], model_regs[2]);
    for (int i = 0; i < 3; i++) begin
      check_eq("col_rvalid_hold", s_axi_rvalid, 1'b1);
      check_eq("col_rdata_old", s_axi_rdata, old_val);
      if (i == 2) s_axi_rready = 1'b1;
      @(negedge clk);
    end
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    check_eq("col_rvalid_clear", s_axi_rvalid, 1'b0);
    check_eq("col_bvalid_clear", s_axi_bvalid, 1'b0);
    axi_read(4'h8, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end else begin
        axi_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end
    end
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // Reset in the middle of a write (AW accepted, W never sent).
    s_axi_awaddr  = 4'h4;
    s_axi_awvalid = 1'b1;
    check_eq("mid_awready", s_axi_awready, 1'b1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    areset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_rst_outputs", out_bundle(), '0);
      check_eq("mid_rst_slv_regs", slv_regs, '0);
    end
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("mid_no_bvalid", s_axi_bvalid, 1'b0);
    end
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);
    // W alone must not complete a write against a stale address.
    axi_write(4'h0, 32'h1234_5678, 4'hF, 4, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
